// File: rtl/clockn_trigger_pkg.sv
// Shared constants and types for the clockn_trigger divider: default divide
// ratios, the 2-bit ratio index and the index-to-ratio mapping.
package clockn_trigger_pkg;

    localparam int unsigned DIV0_DEFAULT = 4;
    localparam int unsigned DIV1_DEFAULT = 8;
    localparam int unsigned DIV2_DEFAULT = 16;
    localparam int unsigned DIV3_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDX_DIV0 = 2'b00,
        IDX_DIV1 = 2'b01,
        IDX_DIV2 = 2'b10,
        IDX_DIV3 = 2'b11
    } ratio_idx_t;

    function automatic int unsigned ratio_of(
        input ratio_idx_t  idx,
        input int unsigned d0,
        input int unsigned d1,
        input int unsigned d2,
        input int unsigned d3
    );
        case (idx)
            IDX_DIV1: return d1;
            IDX_DIV2: return d2;
            IDX_DIV3: return d3;
            default:  return d0;
        endcase
    endfunction

endpackage

// File: rtl/clockn_trigger_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset, W bits wide.
module clockn_trigger_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/clockn_trigger.sv
// Programmable clock divider: 50%/25% duty outputs from fastclk, ratio changes
// and trigger enable both taking effect only on whole output periods.
module clockn_trigger
    import clockn_trigger_pkg::*;
#(
    parameter int unsigned DIV0  = DIV0_DEFAULT,
    parameter int unsigned DIV1  = DIV1_DEFAULT,
    parameter int unsigned DIV2  = DIV2_DEFAULT,
    parameter int unsigned DIV3  = DIV3_DEFAULT,
    parameter int unsigned CNT_W = 6
) (
    input  logic       fastclk,
    input  logic       reset,
    input  logic [1:0] Switches,
    input  logic       trigger,
    output logic       clk_out,
    output logic       clk_out_DC,
    output logic       Clock_sel,
    output logic       Trig_sel,
    output logic       Trig_en
);

    // One extra bit so a ratio equal to 2^CNT_W is still representable.
    localparam int unsigned N_W = CNT_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [N_W-1:0]   n;
    ratio_idx_t       idx;
    logic [1:0]       sw_s2;
    logic             trig_s2;
    logic             wrap;

    clockn_trigger_sync2 #(.W(2)) u_sw_sync (
        .clk   (fastclk),
        .rst_n (reset),
        .d     (Switches),
        .q     (sw_s2)
    );

    clockn_trigger_sync2 #(.W(1)) u_trig_sync (
        .clk   (fastclk),
        .rst_n (reset),
        .d     (trigger),
        .q     (trig_s2)
    );

    assign wrap = ({1'b0, cnt} == (n - 1'b1));

    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            n          <= N_W'(DIV0);
            idx        <= IDX_DIV0;
            clk_out    <= 1'b0;
            clk_out_DC <= 1'b0;
            Trig_en    <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + 1'b1;
            clk_out    <= ({1'b0, cnt} < (n >> 1));
            clk_out_DC <= ({1'b0, cnt} < (n >> 2));
            // Ratio and trigger are sampled on the last cycle of the old period,
            // so the next period starts cleanly with the new settings.
            if (wrap) begin
                idx     <= ratio_idx_t'(sw_s2);
                n       <= N_W'(ratio_of(ratio_idx_t'(sw_s2), DIV0, DIV1, DIV2, DIV3));
                Trig_en <= trig_s2;
            end
        end
    end

    assign Clock_sel = idx[0];
    assign Trig_sel  = idx[1];

endmodule

// File: tb/tb_clockn_trigger.sv
// Directed bench for clockn_trigger: period/duty per ratio, glitch-free ratio
// changes, trigger gating and mid-period reset.
module tb_clockn_trigger;

    logic       fastclk;
    logic       reset;
    logic [1:0] Switches;
    logic       trigger;
    logic       clk_out;
    logic       clk_out_DC;
    logic       Clock_sel;
    logic       Trig_sel;
    logic       Trig_en;

    int n_checks = 0;
    int n_pass   = 0;

    clockn_trigger #(
        .DIV0  (4),
        .DIV1  (8),
        .DIV2  (16),
        .DIV3  (32),
        .CNT_W (6)
    ) dut (
        .fastclk    (fastclk),
        .reset      (reset),
        .Switches   (Switches),
        .trigger    (trigger),
        .clk_out    (clk_out),
        .clk_out_DC (clk_out_DC),
        .Clock_sel  (Clock_sel),
        .Trig_sel   (Trig_sel),
        .Trig_en    (Trig_en)
    );

    initial begin
        fastclk = 1'b0;
        forever #2 fastclk = ~fastclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge fastclk);
        #1;
    endtask

    function automatic int outs();
        return int'({clk_out, clk_out_DC, Trig_sel, Clock_sel, Trig_en});
    endfunction

    // Advance until the sample just after a clk_out rising edge.
    task automatic sync_rise;
        logic prev;
        int   t;
        prev = clk_out;
        t    = 0;
        tick();
        while (!(clk_out && !prev) && t < 200) begin
            prev = clk_out;
            tick();
            t++;
        end
        if (t >= 200) check("sync_rise_timeout", t, 0);
    endtask

    // Entered at a rise sample; leaves at the next rise sample.
    task automatic measure(output int hi, output int per, output int dc, output int trg);
        logic prev;
        hi = 0; per = 0; dc = 0; trg = 0;
        do begin
            per++;
            if (clk_out)    hi++;
            if (clk_out_DC) dc++;
            if (Trig_en)    trg = 1;
            prev = clk_out;
            tick();
        end while (!(clk_out && !prev) && per < 200);
        if (per >= 200) check("measure_timeout", per, 0);
    endtask

    task automatic change_ratio(input logic [1:0] sw, input int old_per, input int new_per);
        int hi, per, dc, trg;
        bit found;
        found = 1'b0;
        hi = 0; per = 0; dc = 0;
        sync_rise();
        Switches = sw;
        for (int t = 0; t < 4 && !found; t++) begin
            measure(hi, per, dc, trg);
            if (per == new_per) found = 1'b1;
            else begin
                check("old_period", per, old_per);
                check("old_high", hi, old_per / 2);
            end
        end
        check("ratio_switched", int'(found), 1);
        check("new_high", hi, new_per / 2);
        check("new_dc_high", dc, new_per / 4);
        check("sel_after_switch", int'({Trig_sel, Clock_sel}), int'(sw));
    endtask

    initial begin
        int hi, per, dc, trg;
        int first_on, last_on, on_cnt, seen;

        reset    = 1'b1;
        Switches = 2'b00;
        trigger  = 1'b0;
        #1 reset = 1'b0;
        repeat (3) tick();
        check("reset_outputs", outs(), 0);

        // Release on the falling edge; first rising edge drives both clocks high.
        #1 reset = 1'b1;
        tick();
        check("first_edge_clk_out", int'(clk_out), 1);
        check("first_edge_clk_dc", int'(clk_out_DC), 1);
        measure(hi, per, dc, trg);
        check("div4_period", per, 4);
        check("div4_high", hi, 2);
        check("div4_dc_high", dc, 1);
        check("div4_sel", int'({Trig_sel, Clock_sel}), 0);
        check("div4_trig_en", int'(Trig_en), 0);

        // Trigger held 12 cycles from a rise sample (index 0).
        trigger  = 1'b1;
        first_on = -1;
        last_on  = -1;
        on_cnt   = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (Trig_en) begin
                if (first_on < 0) first_on = k;
                last_on = k;
                on_cnt++;
            end
            if (k == 12) trigger = 1'b0;
        end
        check("trig_first_on", first_on, 3);
        check("trig_last_on", last_on, 14);
        check("trig_on_cycles", on_cnt, 12);

        change_ratio(2'b01, 4, 8);
        change_ratio(2'b10, 8, 16);
        change_ratio(2'b11, 16, 32);

        // One-cycle trigger pulse mid-period at DIV3 must never reach Trig_en.
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        seen    = 0;
        for (int k = 0; k < 64; k++) begin
            if (Trig_en) seen = 1;
            tick();
        end
        check("short_trig_dropped", seen, 0);

        change_ratio(2'b10, 32, 16);

        // Mid-period async reset with Switches=11 already pending.
        Switches = 2'b11;
        repeat (3) tick();
        check("pre_reset_clk_out", int'(clk_out), 1);
        #1 reset = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 0);
        repeat (2) tick();
        #1 reset = 1'b1;
        tick();
        check("restart_clk_out", int'(clk_out), 1);
        check("restart_sel", int'({Trig_sel, Clock_sel}), 0);
        measure(hi, per, dc, trg);
        check("restart_period", per, 4);
        check("restart_high", hi, 2);
        check("restart_sel_next", int'({Trig_sel, Clock_sel}), 3);
        measure(hi, per, dc, trg);
        check("restart_div32_period", per, 32);
        check("restart_div32_high", hi, 16);
        check("restart_div32_dc", dc, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
